// File: rtl/barrel_unshifter_seq_if.sv
// Handshake bundle for barrel_unshifter_seq: word/shift/direction in, restored word out.
// master = producer/consumer side, slave = the unshifter.
interface barrel_unshifter_seq_if #(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shift;
    logic             in_left;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_shift, in_left, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shift, in_left, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/barrel_unshifter_seq.sv
// Sequential inverse rotate: undoes a rotation one bit per clock, valid/ready on both sides.
// Optional macro UNSHIFT_SHORTPATH_EN rotates the shorter way round for large shift amounts.
//
// Handshake: a word transfers on any rising edge where valid && ready are both 1;
// valid, once raised, stays high with stable data until that edge.
module barrel_unshifter_seq #(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    barrel_unshifter_seq_if.slave bus,
    output logic                  busy,
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] rot_nxt;
    logic [SHW-1:0]   cnt;
    logic             dir;   // 1 = rotate left, 0 = rotate right

    assign rot_nxt = dir ? {data_r[WIDTH-2:0], data_r[WIDTH-1]}
                         : {data_r[0], data_r[WIDTH-1:1]};

    assign bus.in_ready = (state == IDLE) && rst_n;
    assign busy         = (state != IDLE);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            data_r        <= '0;
            cnt           <= '0;
            dir           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_r <= bus.in_data;
`ifdef UNSHIFT_SHORTPATH_EN
                        // Going WIDTH-s steps the original way lands on the same word.
                        if (int'(bus.in_shift) > WIDTH / 2) begin
                            cnt <= SHW'(WIDTH - int'(bus.in_shift));
                            dir <= bus.in_left;
                        end else begin
                            cnt <= bus.in_shift;
                            dir <= ~bus.in_left;
                        end
`else
                        cnt <= bus.in_shift;
                        dir <= ~bus.in_left;
`endif
                        if (bus.in_shift == '0) begin
                            state         <= HOLD;
                            bus.out_data  <= bus.in_data;
                            bus.out_valid <= 1'b1;
                        end else begin
                            state <= ROT;
                        end
                    end
                end
                ROT: begin
                    data_r <= rot_nxt;
                    cnt    <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state         <= HOLD;
                        bus.out_data  <= rot_nxt;
                        bus.out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_barrel_unshifter_seq.sv
// Self-checking bench for barrel_unshifter_seq (WIDTH=4): directed cases, reset, backpressure,
// exhaustive sweep with random backpressure, all checked by a scoreboard monitor.
module tb_barrel_unshifter_seq;
  localparam int W = 4;
  localparam int S = 2;

  logic clk;
  logic rst_n;
  logic busy;
  logic [1:0] state_dbg;
  logic bp_rand;
  logic ready_force;

  int n_tests;
  int n_fail;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  time          at_q[$];

  barrel_unshifter_seq_if #(.WIDTH(W)) bus ();

  barrel_unshifter_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: forward rotation as the sender applied it
  function automatic logic [W-1:0] fwd_rot(input logic [W-1:0] o, input int s, input logic l);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      if (l) r[(i + s) % W] = o[i];
      else   r[i] = o[(i + s) % W];
    end
    return r;
  endfunction

  // reference: restore the original from a rotated word
  function automatic logic [W-1:0] unrot(input logic [W-1:0] r, input int s, input logic l);
    logic [W-1:0] o;
    for (int i = 0; i < W; i++) begin
      if (l) o[i] = r[(i + s) % W];
      else   o[i] = r[(i - s + W) % W];
    end
    return o;
  endfunction

  function automatic int exp_lat(input int s);
`ifdef UNSHIFT_SHORTPATH_EN
    return (s > W / 2) ? (W - s) : s;
`else
    return s;
`endif
  endfunction

  // out_ready has a single driver
  always @(negedge clk) begin
    if (bp_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    else         bus.out_ready = ready_force;
  end

  // driver: present a word, wait for acceptance, record expectations at the accept edge
  task automatic send(input logic [W-1:0] d, input logic [S-1:0] s, input logic l,
                      input logic [W-1:0] expv);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shift = s;
    bus.in_left  = l;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(expv);
    lat_q.push_back(exp_lat(int'(s)));
    at_q.push_back($time);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    bus.in_shift = S'($urandom);
    bus.in_left  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(bus.in_ready && !bus.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // monitor / scoreboard
  logic         seen;
  logic [W-1:0] held;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          logic [W-1:0] e;
          int  el;
          time t0;
          e  = exp_q.pop_front();
          el = lat_q.pop_front();
          t0 = at_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e));
          check("latency", 32'(($time - 1 - t0) / 10), 32'(el));
        end
        seen = 1'b1;
        held = bus.out_data;
      end else begin
        check("hold_stable", 32'(bus.out_data), 32'(held));
      end
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end else begin
      seen = 1'b0;
    end
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    seen = 1'b0;
    held = '0;
    bp_rand = 1'b0;
    ready_force = 1'b1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shift = '0;
    bus.in_left  = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // case 1
    send(4'b0110, 2'd1, 1'b1, unrot(4'b0110, 1, 1'b1));
    check("c1_model", 32'(unrot(4'b0110, 1, 1'b1)), 32'(4'b0011));
    repeat (2) @(posedge clk);
    #1;
    check("c1_in_ready_back", 32'(bus.in_ready), 32'd1);
    wait_idle();

    // case 2: zero shift
    send(4'b1010, 2'd0, 1'b0, 4'b1010);
    wait_idle();

    // case 3
    send(4'b0001, 2'd3, 1'b0, 4'b1000);
    wait_idle();

    // case 4: backpressure with ignored input activity
    ready_force = 1'b0;
    send(4'b0110, 2'd1, 1'b1, 4'b0011);
    repeat (6) @(posedge clk);
    #2;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1111;
    bus.in_shift = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_out_data", 32'(bus.out_data), 32'(4'b0011));
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    ready_force = 1'b1;
    wait_idle();

    // case 5: reset mid-operation
    send(4'b0001, 2'd3, 1'b0, 4'b1000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    lat_q.delete();
    at_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    send(4'b1001, 2'd2, 1'b1, unrot(4'b1001, 2, 1'b1));
    wait_idle();

    // case 6: exhaustive sweep, random backpressure and gaps
    bp_rand = 1'b1;
    for (int d = 0; d < 16; d++) begin
      for (int s = 0; s < W; s++) begin
        for (int l = 0; l < 2; l++) begin
          send(fwd_rot(W'(d), s, 1'(l)), S'(s), 1'(l), W'(d));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    end

    // extra random traffic
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] o;
      int s;
      logic l;
      o = W'($urandom);
      s = $urandom_range(0, W - 1);
      l = 1'($urandom);
      send(fwd_rot(o, s, l), S'(s), l, o);
    end
    bp_rand = 1'b0;
    ready_force = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
